// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the common address/data
// types used by decode, write-back and the register-file scoreboard.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/reg_file_scoreboard_pending_counter.sv
// Per-register pending-write counter. Saturating up/down count of writes that
// decode has reserved and write-back has not yet retired. A simultaneous
// inc/dec cancels. A dec at zero holds the count and pulses underflow.
module pending_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              full,
  output logic              zero,
  output logic              underflow
);

  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] count_d;
  logic [PEND_W-1:0] count_q;

  assign count     = count_q;
  assign full      = (count_q == CNT_MAX);
  assign zero      = (count_q == '0);
  assign underflow = dec && !inc && zero;

  // Next count: a lone inc or dec moves the count and saturates at both ends.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && !full) begin
      count_d = count_q + CNT_ONE;
    end else if (dec && !inc && !zero) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Counter state; an asserted reset clears it without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Architectural register file plus pending-write scoreboard. Two bypassed
// read ports feed decode, write-back writes and releases a destination, and
// decode claims destinations. id_stall holds decode while a source has an
// outstanding write or the claimed destination's counter is full.
module reg_file_scoreboard
  import cpu_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  input  logic                  id_claim,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  id_stall,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  release_err
);

  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  word_t             regs_q [NUM_REGS];
  word_t             regs_d [NUM_REGS];
  logic [PEND_W-1:0] cnt    [NUM_REGS];
  logic [NUM_REGS-1:0] full_v;
  logic [NUM_REGS-1:0] zero_v;
  logic [NUM_REGS-1:0] uflow_v;

  logic rs1_busy;
  logic rs2_busy;
  logic claim_ok;
  logic release_ok;
  logic release_err_d;
  logic release_err_q;

  // r0 has no counter: never busy, never full, never underflows.
  assign cnt[0]     = '0;
  assign full_v[0]  = 1'b0;
  assign zero_v[0]  = 1'b1;
  assign uflow_v[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    pending_counter #(
      .PEND_W (PEND_W)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (claim_ok && (id_rd == REG_ADDR_W'(g))),
      .dec       (release_ok && (wb_rd == REG_ADDR_W'(g))),
      .count     (cnt[g]),
      .full      (full_v[g]),
      .zero      (zero_v[g]),
      .underflow (uflow_v[g])
    );
  end

  // Read ports: r0 reads zero, a same-cycle write-back is forwarded.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = (wb_we && (wb_rd == rs1_addr)) ? wb_data : regs_q[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_data = (wb_we && (wb_rd == rs2_addr)) ? wb_data : regs_q[rs2_addr];
    end
  end

  // Scoreboard: a source whose last pending write is retiring now is not busy.
  always_comb begin
    rs1_busy   = !zero_v[rs1_addr] &&
                 !(wb_we && (wb_rd == rs1_addr) && (cnt[rs1_addr] == CNT_ONE));
    rs2_busy   = !zero_v[rs2_addr] &&
                 !(wb_we && (wb_rd == rs2_addr) && (cnt[rs2_addr] == CNT_ONE));
    id_stall   = ((rs1_addr != '0) && rs1_busy) ||
                 ((rs2_addr != '0) && rs2_busy) ||
                 (id_claim && (id_rd != '0) && full_v[id_rd]);
    claim_ok   = id_claim && !id_stall && (id_rd != '0);
    release_ok = wb_we && (wb_rd != '0);
  end

  // Next register contents: write-back lands in any register except r0.
  always_comb begin
    regs_d = regs_q;
    if (release_ok) begin
      regs_d[wb_rd] = wb_data;
    end
  end

  // Sticky release error: any counter released while already empty.
  always_comb begin
    release_err_d = release_err_q || (|uflow_v);
  end

  // Register array and error flag; reset clears both asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q        <= '{default: '0};
      release_err_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      release_err_q <= release_err_d;
    end
  end

  assign release_err = release_err_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: directed scenarios followed by random
// traffic, every output checked against a behavioural model of the rules.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        id_claim = 1'b0;
  logic [4:0]  id_rd = '0;
  logic        id_stall;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        release_err;

  int compared = 0;
  int mismatched = 0;

  // Reference state: register values, outstanding writes, sticky error.
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  bit          m_err;

  reg_file_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .id_claim    (id_claim),
    .id_rd       (id_rd),
    .id_stall    (id_stall),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .release_err (release_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input int a);
    if (a == 0) return 32'h0;
    if (wb_we && int'(wb_rd) == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input int r);
    if (r == 0 || m_cnt[r] == 0) return 1'b0;
    if (wb_we && int'(wb_rd) == r && m_cnt[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_stall();
    return exp_busy(int'(rs1_addr)) || exp_busy(int'(rs2_addr)) ||
           (id_claim && id_rd != 0 && m_cnt[id_rd] == 3);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rs1_data"}, rs1_data, exp_read(int'(rs1_addr)));
    check({tag, ".rs2_data"}, rs2_data, exp_read(int'(rs2_addr)));
    check({tag, ".id_stall"}, {31'b0, id_stall}, {31'b0, exp_stall()});
    check({tag, ".release_err"}, {31'b0, release_err}, {31'b0, m_err});
  endtask

  // One cycle: inputs were set after a falling edge; check, clock, update model.
  task automatic cycle(input string tag);
    bit acc;
    bit rel;
    #1;
    check_outputs(tag);
    acc = id_claim && !exp_stall() && id_rd != 0;
    rel = wb_we && wb_rd != 0;
    @(posedge clk);
    if (!(acc && rel && id_rd == wb_rd)) begin
      if (acc) m_cnt[id_rd]++;
      if (rel) begin
        if (m_cnt[wb_rd] == 0) m_err = 1'b1;
        else m_cnt[wb_rd]--;
      end
    end
    if (rel) m_reg[wb_rd] = wb_data;
    @(negedge clk);
  endtask

  task automatic idle();
    id_claim = 1'b0;
    wb_we    = 1'b0;
    id_rd    = '0;
    wb_rd    = '0;
  endtask

  task automatic set_in(input int r1, input int r2, input bit cl, input int rd,
                        input bit we, input int wr, input logic [31:0] wd);
    rs1_addr = 5'(r1);
    rs2_addr = 5'(r2);
    id_claim = cl;
    id_rd    = 5'(rd);
    wb_we    = we;
    wb_rd    = 5'(wr);
    wb_data  = wd;
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // Reset state on every register through both ports.
    for (int i = 0; i < 32; i++) begin
      set_in(i, 31 - i, 0, 0, 0, 0, 32'h0);
      cycle("reset_read");
    end

    // Claim r5, dependent read stalls, write-back clears stall in its cycle.
    set_in(0, 0, 1, 5, 0, 0, 32'h0);       cycle("claim5");
    set_in(5, 0, 0, 0, 0, 0, 32'h0);       cycle("dep5_c1");
    check("dep5_stall_hi", {31'b0, id_stall}, 32'd1);
    cycle("dep5_c2");
    set_in(5, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    #1;
    check("wb5_bypass", rs1_data, 32'hDEADBEEF);
    check("wb5_unstall", {31'b0, id_stall}, 32'd0);
    cycle("wb5");
    set_in(5, 5, 0, 0, 0, 0, 32'h0);       cycle("read5");

    // Three claims fill r7, a fourth is refused, three releases drain it.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 7, 0, 0, 32'h0);     cycle("claim7");
    end
    set_in(0, 0, 1, 7, 0, 0, 32'h0);
    #1;
    check("claim7_full_stall", {31'b0, id_stall}, 32'd1);
    cycle("claim7_4th");
    for (int i = 0; i < 3; i++) begin
      set_in(7, 0, 0, 0, 1, 7, 32'h700 + 32'(i));
      cycle("rel7");
    end
    set_in(7, 7, 0, 0, 0, 0, 32'h0);       cycle("after7");
    check("r7_value", rs1_data, 32'h702);

    // Same-cycle claim and release of r9 leaves the count at 1.
    set_in(0, 0, 1, 9, 0, 0, 32'h0);       cycle("claim9");
    set_in(0, 0, 1, 9, 1, 9, 32'h99);      cycle("claimrel9");
    set_in(9, 0, 0, 0, 0, 0, 32'h0);       cycle("dep9");
    check("r9_still_busy", {31'b0, id_stall}, 32'd1);
    set_in(0, 0, 0, 0, 1, 9, 32'h9A);      cycle("rel9");

    // r0: writes discarded, claims ignored.
    set_in(0, 0, 1, 0, 1, 0, 32'h1234);    cycle("r0_wr_claim");
    set_in(0, 0, 0, 0, 0, 0, 32'h0);       cycle("r0_read");
    check("r0_no_err", {31'b0, release_err}, 32'd0);

    // Release r12 at count 0 sets the sticky error.
    set_in(0, 0, 0, 0, 1, 12, 32'hC);      cycle("rel12_empty");
    set_in(12, 0, 0, 0, 0, 0, 32'h0);      cycle("err_sticky1");
    check("err_set", {31'b0, release_err}, 32'd1);
    cycle("err_sticky2");

    // Asynchronous reset with pending claims and written registers.
    set_in(0, 0, 1, 3, 0, 0, 32'h0);       cycle("claim3");
    set_in(0, 0, 1, 4, 1, 3, 32'h3333);    cycle("claim4_wb3");
    set_in(4, 3, 0, 0, 0, 0, 32'h0);
    #2 reset = 1'b0;
    model_clear();
    #1;
    check_outputs("async_reset");
    check("async_r3_zero", rs2_data, 32'h0);
    check("async_err_clr", {31'b0, release_err}, 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);

    // Random traffic over a small register window.
    for (int n = 0; n < 400; n++) begin
      int wr;
      wr = $urandom_range(0, 7);
      if (m_cnt[wr] == 0 && $urandom_range(0, 9) < 8) begin
        for (int k = 1; k < 8; k++) if (m_cnt[k] != 0) wr = k;
      end
      set_in($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1) == 1,
             $urandom_range(0, 7), $urandom_range(0, 9) < 4, wr, $urandom);
      cycle("rand");
    end

    // Reset mid-stream, then an in-flight release raises the error.
    idle();
    set_in(0, 0, 1, 6, 0, 0, 32'h0);       cycle("claim6");
    set_in(6, 0, 0, 0, 0, 0, 32'h0);
    #2 reset = 1'b0;
    model_clear();
    #1;
    check_outputs("reset2");
    #1 reset = 1'b1;
    @(negedge clk);
    set_in(6, 0, 0, 0, 1, 6, 32'h66);      cycle("late_wb6");
    set_in(6, 0, 0, 0, 0, 0, 32'h0);       cycle("late_err");
    check("late_err_set", {31'b0, release_err}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
